ikaopll_bus_writer: RTL and testbench



---
 rtl/ikaopll_bus_writer.sv | 237 +++++++++++++++++++++++
 tb/tb_ikaopll_bus_writer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_bus_writer.sv
// ikaopll_bus_writer: host-side initiator for the OPLL CPU bus.
// Buffers (register address, data) write requests in a FIFO and replays each
// one as a YM2413 address write followed by a data write, honouring the
// chip's post-write wait times. The sequencer advances only on phiM enables.
//
// Ports:
//   i_EMUCLK       master clock (same as XIN)
//   i_RST_n        asynchronous active-low reset
//   i_phiM_PCEN_n  phiM positive-edge clock enable, active low
//   i_REQ_VALID    request valid
//   o_REQ_READY    FIFO can accept a request (registered)
//   i_REQ_ADDR     OPLL register address
//   i_REQ_DATA     OPLL register data
//   o_CS_n         chip select to core
//   o_WR_n         write strobe to core
//   o_A0           0 = address phase, 1 = data phase
//   o_D            bus data to core
//   o_BUSY         sequencer not idle or FIFO not empty
//   o_FIFO_LEVEL   current FIFO occupancy
module ikaopll_bus_writer #(
  parameter int unsigned ADDR_WAIT       = 12,
  parameter int unsigned DATA_WAIT       = 84,
  parameter int unsigned PULSE_LEN       = 2,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic                       i_EMUCLK,
  input  logic                       i_RST_n,
  input  logic                       i_phiM_PCEN_n,
  input  logic                       i_REQ_VALID,
  output logic                       o_REQ_READY,
  input  logic [7:0]                 i_REQ_ADDR,
  input  logic [7:0]                 i_REQ_DATA,
  output logic                       o_CS_n,
  output logic                       o_WR_n,
  output logic                       o_A0,
  output logic [7:0]                 o_D,
  output logic                       o_BUSY,
  output logic [FIFO_DEPTH_LOG2:0]   o_FIFO_LEVEL
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned ENT_W = 16;
  localparam int unsigned CNT_W = 7;

  // Counters load N-1 and terminate at 0; a length of 0 behaves like 1.
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'((PULSE_LEN == 0) ? 0 : PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] AWAIT_LOAD = CNT_W'((ADDR_WAIT == 0) ? 0 : ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] DWAIT_LOAD = CNT_W'((DATA_WAIT == 0) ? 0 : DATA_WAIT - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_HOLD   = 4'd3,
    ST_A_WAIT   = 4'd4,
    ST_D_SETUP  = 4'd5,
    ST_D_STROBE = 4'd6,
    ST_D_HOLD   = 4'd7,
    ST_D_WAIT   = 4'd8
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ready_q, ready_d;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;

  assign push       = i_REQ_VALID & ready_q;
  assign fifo_empty = (level_q == LVL_W'(0));
  assign head       = mem_q[rd_ptr_q];

  // Pointer/level next state; ready tracks the post-edge level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    ready_d = (level_d != LVL_W'(DEPTH));
  end

  // Storage is not reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge i_EMUCLK) begin
    if (push) mem_q[wr_ptr_q] <= {i_REQ_ADDR, i_REQ_DATA};
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
    end
  end

  // ----------------------------------------------------------- sequencer
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_q, cs_d;
  logic             wr_q, wr_d;
  logic             a0_q, a0_d;
  logic [7:0]       d_q, d_d;
  logic [7:0]       data_hold_q, data_hold_d;
  logic             start;

  // Next-state and next-output logic; everything holds on disabled cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    wr_d        = wr_q;
    a0_d        = a0_q;
    d_d         = d_q;
    data_hold_d = data_hold_q;
    start       = 1'b0;
    pop         = 1'b0;
    if (!i_phiM_PCEN_n) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) start = 1'b1;
        end
        ST_A_SETUP: begin
          state_d = ST_A_STROBE;
          wr_d    = 1'b0;
          cnt_d   = PULSE_LOAD;
        end
        ST_A_STROBE: begin
          if (cnt_q == CNT_W'(0)) begin
            state_d = ST_A_HOLD;
            wr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_A_HOLD: begin
          state_d = ST_A_WAIT;
          cs_d    = 1'b1;
          cnt_d   = AWAIT_LOAD;
        end
        ST_A_WAIT: begin
          if (cnt_q == CNT_W'(0)) begin
            state_d = ST_D_SETUP;
            cs_d    = 1'b0;
            a0_d    = 1'b1;
            d_d     = data_hold_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_D_SETUP: begin
          state_d = ST_D_STROBE;
          wr_d    = 1'b0;
          cnt_d   = PULSE_LOAD;
        end
        ST_D_STROBE: begin
          if (cnt_q == CNT_W'(0)) begin
            state_d = ST_D_HOLD;
            wr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_D_HOLD: begin
          state_d = ST_D_WAIT;
          cs_d    = 1'b1;
          cnt_d   = DWAIT_LOAD;
        end
        ST_D_WAIT: begin
          // Chain straight into the next transaction when work is queued.
          if (cnt_q == CNT_W'(0)) begin
            if (!fifo_empty) start = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
        end
      endcase
      if (start) begin
        pop         = 1'b1;
        state_d     = ST_A_SETUP;
        cs_d        = 1'b0;
        wr_d        = 1'b1;
        a0_d        = 1'b0;
        d_d         = head[15:8];
        data_hold_d = head[7:0];
      end
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cs_q        <= 1'b1;
      wr_q        <= 1'b1;
      a0_q        <= 1'b0;
      d_q         <= '0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      a0_q        <= a0_d;
      d_q         <= d_d;
      data_hold_q <= data_hold_d;
    end
  end

  assign o_REQ_READY  = ready_q;
  assign o_CS_n       = cs_q;
  assign o_WR_n       = wr_q;
  assign o_A0         = a0_q;
  assign o_D          = d_q;
  assign o_FIFO_LEVEL = level_q;
  assign o_BUSY       = (state_q != ST_IDLE) | (level_q != LVL_W'(0));

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// Testbench for ikaopll_bus_writer (default parameters).
module tb_ikaopll_bus_writer;

  localparam int P        = 2;
  localparam int AW       = 12;
  localparam int DW       = 84;
  localparam int DEPTH    = 8;
  localparam int TLEN     = 4 + 2 * P + AW + DW;  // 104 enabled cycles
  localparam int T_DSETUP = 2 + P + AW;           // data phase begins at 16
  localparam int NS       = 900;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pcen_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       ready, cs_n, wr_n, a0, busy;
  logic [7:0] d;
  logic [3:0] level;

  int tests = 0;
  int fails = 0;
  int en_div = 1;     // 0 = random enables, N = one enable every N clocks
  bit en_block = 1'b0;

  ikaopll_bus_writer dut (
    .i_EMUCLK      (clk),
    .i_RST_n       (rst_n),
    .i_phiM_PCEN_n (pcen_n),
    .i_REQ_VALID   (req_valid),
    .o_REQ_READY   (ready),
    .i_REQ_ADDR    (req_addr),
    .i_REQ_DATA    (req_data),
    .o_CS_n        (cs_n),
    .o_WR_n        (wr_n),
    .o_A0          (a0),
    .o_D           (d),
    .o_BUSY        (busy),
    .o_FIFO_LEVEL  (level)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Clock-enable generator, updated between active edges.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (en_div > 0) ph = (ph + 1) % en_div;
      else            ph = 0;
      if (en_block)         pcen_n = 1'b1;
      else if (en_div == 0) pcen_n = 1'($urandom_range(0, 1));
      else                  pcen_n = (ph != 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: request queue + transaction timeline
  typedef struct packed { logic [7:0] a; logic [7:0] d; } req_t;
  req_t       mq[$];
  req_t       cur;
  bit         in_tx = 1'b0;
  int         t = 0;
  bit         m_ready = 1'b1;
  logic       m_a0 = 1'b0;
  logic [7:0] m_d = '0;
  logic       e_cs, e_wr, e_a0, e_busy, e_ready;
  logic [7:0] e_d;
  logic [3:0] e_level;
  int         printed = 0;

  initial begin
    bit en, acc;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        in_tx = 1'b0; t = 0; m_ready = 1'b1; m_a0 = 1'b0; m_d = '0;
      end else begin
        en  = !pcen_n;
        acc = req_valid && m_ready;
        if (en) begin
          if (in_tx) begin
            t++;
            if (t == TLEN) in_tx = 1'b0;
          end
          if (!in_tx && mq.size() > 0) begin
            cur = mq.pop_front();
            in_tx = 1'b1;
            t = 0;
          end
        end
        if (acc) mq.push_back(req_t'({req_addr, req_data}));
        m_ready = (mq.size() < DEPTH);
      end
      if (in_tx) begin
        e_a0 = (t >= T_DSETUP);
        e_d  = e_a0 ? cur.d : cur.a;
        e_cs = !((t <= P + 1) || (t >= T_DSETUP && t <= T_DSETUP + P + 1));
        e_wr = !((t >= 1 && t <= P) || (t >= T_DSETUP + 1 && t <= T_DSETUP + P));
        m_a0 = e_a0;
        m_d  = e_d;
      end else begin
        e_cs = 1'b1; e_wr = 1'b1; e_a0 = m_a0; e_d = m_d;
      end
      e_busy  = in_tx || (mq.size() != 0);
      e_level = 4'(mq.size());
      e_ready = m_ready;
      @(negedge clk);
      if (rst_n) begin
        tests++;
        if ({cs_n, wr_n, a0, d, ready, busy, level} !==
            {e_cs, e_wr, e_a0, e_d, e_ready, e_busy, e_level}) begin
          fails++;
          if (printed < 20) begin
            printed++;
            $display("FAIL bus_model @%0t: cs/wr/a0/d/rdy/busy/lvl got %b/%b/%b/%02h/%b/%b/%0d expected %b/%b/%b/%02h/%b/%b/%0d",
                     $time, cs_n, wr_n, a0, d, ready, busy, level,
                     e_cs, e_wr, e_a0, e_d, e_ready, e_busy, e_level);
          end
        end
      end
    end
  end

  // Push one request, waiting (bounded) for ready. Call just after an edge.
  task automatic push(input logic [7:0] a, input logic [7:0] dd, output bit ok);
    ok = 1'b0;
    req_valid = 1'b1; req_addr = a; req_data = dd;
    for (int n = 0; n < 2000; n++) begin
      if (ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // Per-clock capture used by the table vectors.
  logic       s_cs[NS], s_wr[NS], s_a0[NS], s_busy[NS];
  logic [7:0] s_d[NS];
  int         ns;

  function automatic int find_cs(input int from, input logic val);
    if (from < 0) return -1;
    for (int i = from; i < ns; i++) if (s_cs[i] === val) return i;
    return -1;
  endfunction

  function automatic int find_wr(input int from, input logic val);
    if (from < 0) return -1;
    for (int i = from; i < ns; i++) if (s_wr[i] === val) return i;
    return -1;
  endfunction

  function automatic int find_busy(input int from, input logic val);
    if (from < 0) return -1;
    for (int i = from; i < ns; i++) if (s_busy[i] === val) return i;
    return -1;
  endfunction

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         div;
    int         exp_wr_low;
    int         exp_gap;
    int         exp_total;
  } vec_t;

  initial begin
    vec_t vecs[4];
    bit   ok;
    int   n, s0, wf1, wr1, cr, c2, wf2, wr2, b;
    logic       f_cs, f_wr, f_a0, f_busy;
    logic [7:0] f_d;

    vecs[0] = '{8'h10, 8'h5A, 1, 2, 13, 104};
    vecs[1] = '{8'h10, 8'h5A, 4, 8, 52, 416};
    vecs[2] = '{8'h3F, 8'hC3, 2, 4, 26, 208};
    vecs[3] = '{8'h00, 8'hFF, 3, 6, 39, 312};

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_wr_n", int'(wr_n), 1);
    chk("rst_a0", int'(a0), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);

    // Single writes at several enable rates
    for (int v = 0; v < 4; v++) begin
      en_div = vecs[v].div;
      push(vecs[v].addr, vecs[v].data, ok);
      chk("tbl_push_accept", int'(ok), 1);
      ns = 0;
      for (int i = 0; i < NS; i++) begin
        s_cs[i] = cs_n; s_wr[i] = wr_n; s_a0[i] = a0; s_d[i] = d; s_busy[i] = busy;
        ns = i + 1;
        if (i > 0 && !busy) break;
        @(posedge clk); #1;
      end
      s0  = find_cs(0, 1'b0);
      wf1 = find_wr(s0, 1'b0);
      wr1 = find_wr(wf1, 1'b1);
      cr  = find_cs(wr1, 1'b1);
      c2  = find_cs(cr, 1'b0);
      wf2 = find_wr(c2, 1'b0);
      wr2 = find_wr(wf2, 1'b1);
      b   = find_busy(s0, 1'b0);
      if (vecs[v].div == 1) chk("tbl_start_latency", s0, 1);
      chk("tbl_addr_wr_low", wr1 - wf1, vecs[v].exp_wr_low);
      chk("tbl_addr_to_data_gap", c2 - wr1, vecs[v].exp_gap);
      chk("tbl_data_wr_low", wr2 - wf2, vecs[v].exp_wr_low);
      chk("tbl_total", b - s0, vecs[v].exp_total);
      chk("tbl_addr_phase_d", (s0 >= 0) ? int'(s_d[s0]) : -1, int'(vecs[v].addr));
      chk("tbl_addr_phase_a0", (s0 >= 0) ? int'(s_a0[s0]) : -1, 0);
      chk("tbl_data_phase_d", (c2 >= 0) ? int'(s_d[c2]) : -1, int'(vecs[v].data));
      chk("tbl_data_phase_a0", (c2 >= 0) ? int'(s_a0[c2]) : -1, 1);
    end

    // Back-to-back requests, no idle gap between transactions
    en_div = 1;
    en_block = 1'b1;
    push(8'h20, 8'h11, ok); chk("b2b_level1", int'(level), 1);
    push(8'h21, 8'h12, ok); chk("b2b_level2", int'(level), 2);
    push(8'h22, 8'h13, ok); chk("b2b_level3", int'(level), 3);
    en_block = 1'b0;
    for (n = 1; n < 2000; n++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk("b2b_total_clocks", n, 313);

    // Overflow: ninth request held off until the first pop
    en_block = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(8'(8'h40 + k), 8'(8'h80 + k), ok);
      chk("ovf_push_ok", int'(ok), 1);
    end
    chk("ovf_ready_low", int'(ready), 0);
    chk("ovf_level_full", int'(level), 8);
    req_addr = 8'h4F; req_data = 8'h8F; req_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_held_off_level", int'(level), 8);
    chk("ovf_held_off_ready", int'(ready), 0);
    en_block = 1'b0;
    push(8'h4F, 8'h8F, ok);
    chk("ovf_ninth_accept", int'(ok), 1);
    for (n = 0; n < 3000; n++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("ovf_drained", int'(busy), 0);

    // Asynchronous reset during the address strobe
    push(8'h33, 8'h44, ok);
    push(8'h35, 8'h46, ok);
    push(8'h36, 8'h47, ok);
    for (n = 0; n < 200; n++) begin
      if (!wr_n) break;
      @(posedge clk); #1;
    end
    chk("rst_mid_reached_strobe", int'(wr_n), 0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_n", int'(wr_n), 1);
    chk("rst_mid_cs_n", int'(cs_n), 1);
    chk("rst_mid_level", int'(level), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    chk("rst_after_idle_busy", int'(busy), 0);
    chk("rst_after_idle_cs_n", int'(cs_n), 1);

    // Enable held inactive for 50 clocks in the middle of the data wait
    push(8'h55, 8'hAA, ok);
    for (n = 0; n < 300; n++) begin
      if (a0 && cs_n) break;
      @(posedge clk); #1;
    end
    chk("frz_reached_dwait", int'(a0 && cs_n), 1);
    repeat (10) @(posedge clk);
    #1;
    en_block = 1'b1;
    @(posedge clk); #1;
    f_cs = cs_n; f_wr = wr_n; f_a0 = a0; f_d = d; f_busy = busy;
    repeat (50) @(posedge clk);
    #1;
    chk("frz_cs_n", int'(cs_n), int'(f_cs));
    chk("frz_wr_n", int'(wr_n), int'(f_wr));
    chk("frz_a0", int'(a0), int'(f_a0));
    chk("frz_d", int'(d), int'(f_d));
    chk("frz_busy", int'(busy), int'(f_busy));
    en_block = 1'b0;
    for (n = 1; n < 500; n++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk("frz_resume_clocks", n, 74);

    // Random traffic with varied enable patterns and push rates
    for (int seg = 0; seg < 4; seg++) begin
      en_div = seg % 3;
      for (int c = 0; c < 1500; c++) begin
        req_valid = ($urandom_range(0, 99) < ((seg % 2 == 1) ? 35 : 3));
        req_addr  = 8'($urandom);
        req_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    en_div = 1;
    for (n = 0; n < 4000; n++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("rnd_drained_busy", int'(busy), 0);
    chk("rnd_drained_level", int'(level), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
